// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer and its decode/bench users.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Slice select codes for the two arithmetic operations the sequencer is normally driven with.
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;

    localparam logic [3:0] DEC_LIMIT = 4'd9;
    localparam logic [3:0] DEC_ADJ   = 4'd6;

endpackage

// File: rtl/alu4.sv
// 4-bit ALU slice: M=1 selects arithmetic with carry, M=0 selects one of sixteen bitwise functions.
module alu4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    input  logic       m_i,
    input  logic [3:0] s_i,
    output logic [3:0] f_o,
    output logic       co_o,
    output logic       g_o,
    output logic       p_o
);

    logic [3:0] y;
    logic [4:0] sum;
    logic [3:0] lf;
    logic [3:0] gen;
    logic [3:0] prop;

    // Second adder operand; subtract is A + ~B + CI so CI=1 means no borrow.
    always_comb begin
        case (s_i)
            4'b0000: y = 4'h0;
            4'b0110: y = ~b_i;
            4'b1001: y = b_i;
            4'b1100: y = a_i;
            4'b1111: y = 4'hF;
            default: y = b_i;
        endcase
    end

    always_comb begin
        case (s_i)
            4'h0:    lf = ~a_i;
            4'h1:    lf = ~(a_i | b_i);
            4'h2:    lf = ~a_i & b_i;
            4'h3:    lf = 4'h0;
            4'h4:    lf = ~(a_i & b_i);
            4'h5:    lf = ~b_i;
            4'h6:    lf = a_i ^ b_i;
            4'h7:    lf = a_i & ~b_i;
            4'h8:    lf = ~a_i | b_i;
            4'h9:    lf = ~(a_i ^ b_i);
            4'hA:    lf = b_i;
            4'hB:    lf = a_i & b_i;
            4'hC:    lf = 4'hF;
            4'hD:    lf = a_i | ~b_i;
            4'hE:    lf = a_i | b_i;
            default: lf = a_i;
        endcase
    end

    assign sum  = {1'b0, a_i} + {1'b0, y} + {4'b0000, ci_i};
    assign gen  = a_i & y;
    assign prop = a_i | y;

    assign f_o  = m_i ? sum[3:0] : lf;
    assign co_o = m_i & sum[4];
    assign g_o  = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                | (prop[3] & prop[2] & prop[1] & gen[0]);
    assign p_o  = &prop;

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs a W-bit ALU operation through one alu4 slice, low nibble first, with per-nibble BCD adjust
// and 6502-style N/Z/C/V flags registered on the final pass.
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   ci,
    input  logic                   m,
    input  logic [3:0]             s,
    input  logic                   sub,
    input  logic                   dec,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   flag_c,
    output logic                   flag_v,
    output logic                   flag_n,
    output logic                   flag_z
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          ci_q, ci_d;
    logic          m_q, m_d;
    logic [3:0]    s_q, s_d;
    logic          sub_q, sub_d;
    logic          dec_q, dec_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [W-1:0]  result_q, result_d;
    logic          flag_c_q, flag_c_d;
    logic          flag_v_q, flag_v_d;
    logic          flag_n_q, flag_n_d;
    logic          flag_z_q, flag_z_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    slice_f;
    logic          slice_co;
    logic          slice_g_unused;
    logic          slice_p_unused;
    logic [3:0]    f_adj;
    logic          carry_adj;
    logic [W-1:0]  asm_wr;

    assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
    assign nib_b = b_q[{cnt_q, 2'b00} +: 4];

    alu4 u_slice (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .ci_i (carry_q),
        .m_i  (m_q),
        .s_i  (s_q),
        .f_o  (slice_f),
        .co_o (slice_co),
        .g_o  (slice_g_unused),
        .p_o  (slice_p_unused)
    );

    // Subtract never forces a carry: the slice carry already means "no borrow" for the next digit.
    always_comb begin
        f_adj     = slice_f;
        carry_adj = slice_co;
        if (m_q && dec_q) begin
            if (!sub_q) begin
                if (slice_co || (slice_f > DEC_LIMIT)) begin
                    f_adj     = slice_f + DEC_ADJ;
                    carry_adj = 1'b1;
                end
            end else if (!slice_co) begin
                f_adj = slice_f - DEC_ADJ;
            end
        end
    end

    always_comb begin
        asm_wr = asm_q;
        asm_wr[{cnt_q, 2'b00} +: 4] = f_adj;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        ci_d     = ci_q;
        m_d      = m_q;
        s_d      = s_q;
        sub_d    = sub_q;
        dec_d    = dec_q;
        asm_d    = asm_q;
        result_d = result_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    ci_d    = ci;
                    m_d     = m;
                    s_d     = s;
                    sub_d   = sub;
                    dec_d   = dec;
                    cnt_d   = '0;
                    carry_d = ci;
                    asm_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                asm_d   = asm_wr;
                carry_d = carry_adj;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_NIB) begin
                    result_d = asm_wr;
                    flag_n_d = asm_wr[W-1];
                    flag_z_d = (asm_wr == '0);
                    flag_c_d = m_q ? carry_adj : ci_q;
                    // Overflow looks at the binary top-nibble sum, before any decimal adjust.
                    flag_v_d = m_q & (a_q[W-1] == (b_q[W-1] ^ sub_q))
                                   & (slice_f[3] != a_q[W-1]);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ci_q     <= 1'b0;
            m_q      <= 1'b0;
            s_q      <= 4'h0;
            sub_q    <= 1'b0;
            dec_q    <= 1'b0;
            asm_q    <= '0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ci_q     <= ci_d;
            m_q      <= m_d;
            s_q      <= s_d;
            sub_q    <= sub_d;
            dec_q    <= dec_d;
            asm_q    <= asm_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed scenarios plus randomized operations vs a digit-level model.
module tb_alu_nibble_seq;
    import alu_seq_pkg::*;

    localparam int NIB = 2;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         m;
    logic [3:0]   s;
    logic         sub;
    logic         dec;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag_c;
    logic         flag_v;
    logic         flag_n;
    logic         flag_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ci     (ci),
        .m      (m),
        .s      (s),
        .sub    (sub),
        .dec    (dec),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .flag_n (flag_n),
        .flag_z (flag_z)
    );

    // Reference: {result, C, V, N, Z}. Binary arithmetic is done on the full word; decimal digit by digit.
    function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mci, input logic mm, input logic [3:0] ms,
                                           input logic msub, input logic mdec);
        logic [W-1:0] res;
        logic [W-1:0] bm;
        logic [W:0]   total;
        logic         c;
        logic         v;
        int           carry;
        int           raw;
        int           topbit;
        res = '0;
        bm  = msub ? ~mb : mb;
        if (!mm) begin
            case (ms)
                4'b0110: res = ma ^ mb;
                4'b1011: res = ma & mb;
                4'b1110: res = ma | mb;
                default: res = ma;
            endcase
            c = mci;
            v = 1'b0;
        end else if (!mdec) begin
            total = {1'b0, ma} + {1'b0, bm} + (W+1)'(mci);
            res   = total[W-1:0];
            c     = total[W];
            v     = (ma[W-1] == bm[W-1]) && (res[W-1] != ma[W-1]);
        end else begin
            carry  = int'(mci);
            topbit = 0;
            for (int i = 0; i < NIB; i++) begin
                raw = int'(ma[4*i +: 4]) + int'(bm[4*i +: 4]) + carry;
                if (i == NIB - 1) topbit = (raw >> 3) & 1;
                if (!msub) begin
                    if (raw > 9) begin
                        res[4*i +: 4] = 4'((raw + 6) % 16);
                        carry = 1;
                    end else begin
                        res[4*i +: 4] = 4'(raw);
                        carry = 0;
                    end
                end else begin
                    if (raw < 16) begin
                        res[4*i +: 4] = 4'((raw - 6) & 15);
                        carry = 0;
                    end else begin
                        res[4*i +: 4] = 4'(raw - 16);
                        carry = 1;
                    end
                end
            end
            c = (carry != 0);
            v = (ma[W-1] == bm[W-1]) && ((topbit != 0) != ma[W-1]);
        end
        return {res, c, v, res[W-1], (res == '0)};
    endfunction

    // Drives one operation and waits (bounded) for done; lat counts negedges from start sample to done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                          input logic tm, input logic [3:0] ts, input logic tsub, input logic tdec,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        a = ta; b = tb_v; ci = tci; m = tm; s = ts; sub = tsub; dec = tdec;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 50) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required done=1", done, lat);
        end
        $display("op a=%h b=%h ci=%b m=%b s=%b sub=%b dec=%b -> result=%h C=%b V=%b N=%b Z=%b lat=%0d",
                 ta, tb_v, tci, tm, ts, tsub, tdec, result, flag_c, flag_v, flag_n, flag_z, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0; m = 1'b0; s = 4'h0; sub = 1'b0; dec = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, result, flag_c, flag_v, flag_n, flag_z} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b%b%b%b, required all 0",
                     busy, done, result, flag_c, flag_v, flag_n, flag_z);
        end
        rst = 1'b0;
    endtask

    task automatic test_binary_add();
        int lat, bc;
        logic [W+3:0] got;
        run_op(8'h3C, 8'h4A, 1'b0, 1'b1, S_ADD, 1'b0, 1'b0, lat, bc);
        got = {result, flag_c, flag_v, flag_n, flag_z};
        n_checks++;
        if (got !== {8'h86, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bin_add: got %h, required %h", got, {8'h86, 4'b0110});
        end
        n_checks++;
        if (lat != NIB + 1) begin
            n_fail++;
            $display("FAIL bin_add_latency: got %0d, required %0d", lat, NIB + 1);
        end
        n_checks++;
        if (bc != NIB) begin
            n_fail++;
            $display("FAIL bin_add_busy_cycles: got %0d, required %0d", bc, NIB);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single_pulse: got done=%b, required 0", done);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({result, flag_c, flag_v, flag_n, flag_z} !== {8'h86, 4'b0110}) begin
            n_fail++;
            $display("FAIL result_hold: got %h, required %h", {result, flag_c, flag_v, flag_n, flag_z},
                     {8'h86, 4'b0110});
        end
    endtask

    task automatic test_decimal_add();
        int lat, bc;
        logic [W+3:0] got;
        run_op(8'h58, 8'h46, 1'b1, 1'b1, S_ADD, 1'b0, 1'b1, lat, bc);
        got = {result, flag_c, flag_v, flag_n, flag_z};
        n_checks++;
        if ({got[W+3:4], got[3], got[1], got[0]} !== {8'h05, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL dec_add: got result=%h C=%b N=%b Z=%b, required result=05 C=1 N=0 Z=0",
                     result, flag_c, flag_n, flag_z);
        end
        n_checks++;
        if (got !== model(8'h58, 8'h46, 1'b1, 1'b1, S_ADD, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL dec_add_model: got %h, required %h", got,
                     model(8'h58, 8'h46, 1'b1, 1'b1, S_ADD, 1'b0, 1'b1));
        end
    endtask

    task automatic test_decimal_sub();
        int lat, bc;
        run_op(8'h32, 8'h15, 1'b1, 1'b1, S_SUB, 1'b1, 1'b1, lat, bc);
        n_checks++;
        if ({result, flag_c, flag_n, flag_z} !== {8'h17, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL dec_sub: got result=%h C=%b N=%b Z=%b, required result=17 C=1 N=0 Z=0",
                     result, flag_c, flag_n, flag_z);
        end
    endtask

    task automatic test_binary_sub_zero();
        int lat, bc;
        run_op(8'h50, 8'h50, 1'b1, 1'b1, S_SUB, 1'b1, 1'b0, lat, bc);
        n_checks++;
        if ({result, flag_c, flag_v, flag_n, flag_z} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bin_sub_zero: got %h, required %h", {result, flag_c, flag_v, flag_n, flag_z},
                     {8'h00, 4'b1001});
        end
    endtask

    task automatic test_logic();
        int lat, bc;
        run_op(8'hA5, 8'h3C, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b1, lat, bc);
        n_checks++;
        if ({result, flag_c, flag_v, flag_n, flag_z} !== {8'h99, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL logic_xor: got %h, required %h", {result, flag_c, flag_v, flag_n, flag_z},
                     {8'h99, 4'b1010});
        end
    endtask

    task automatic test_random();
        int lat, bc, mode;
        logic [W-1:0] ra, rb;
        logic rci, rm, rsub, rdec;
        logic [3:0] rs;
        logic [W+3:0] exp_v;
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 4));
            rci  = 1'($urandom_range(0, 1));
            ra   = W'($urandom);
            rb   = W'($urandom);
            rm   = 1'b1;
            rdec = 1'b0;
            rsub = 1'b0;
            rs   = S_ADD;
            case (mode)
                1: begin rsub = 1'b1; rs = S_SUB; end
                2: begin
                    rdec = 1'b1;
                    ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                end
                3: begin
                    rdec = 1'b1; rsub = 1'b1; rs = S_SUB;
                    ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                end
                4: begin
                    rm = 1'b0;
                    rdec = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 2))
                        0:       rs = 4'b0110;
                        1:       rs = 4'b1011;
                        default: rs = 4'b1110;
                    endcase
                end
                default: ;
            endcase
            exp_v = model(ra, rb, rci, rm, rs, rsub, rdec);
            run_op(ra, rb, rci, rm, rs, rsub, rdec, lat, bc);
            n_checks++;
            if ({result, flag_c, flag_v, flag_n, flag_z} !== exp_v) begin
                n_fail++;
                $display("FAIL random_%0d: got %h, required %h", i,
                         {result, flag_c, flag_v, flag_n, flag_z}, exp_v);
            end
            n_checks++;
            if (lat != NIB + 1) begin
                n_fail++;
                $display("FAIL random_latency_%0d: got %0d, required %0d", i, lat, NIB + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones, wait_cnt;
        logic [W+3:0] exp_v;
        dones = 0;
        @(negedge clk);
        a = 8'h12; b = 8'h34; ci = 1'b0; m = 1'b1; s = S_ADD; sub = 1'b0; dec = 1'b0;
        start = 1'b1;
        @(negedge clk);
        if (done) dones++;
        a = 8'hFF; b = 8'h01;
        @(negedge clk);
        if (done) dones++;
        @(negedge clk);
        if (done) dones++;
        @(negedge clk);
        if (done) dones++;
        n_checks++;
        if (dones != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_ignored: got dones=%0d busy=%b, required dones=1 busy=0", dones, busy);
        end
        n_checks++;
        if ({result, flag_c, flag_v, flag_n, flag_z} !== {8'h46, 4'b0000}) begin
            n_fail++;
            $display("FAIL overlap_result: got %h, required %h", {result, flag_c, flag_v, flag_n, flag_z},
                     {8'h46, 4'b0000});
        end
        $display("op a=12 b=34 with overlapping starts -> result=%h dones=%0d", result, dones);
        a = 8'h99; b = 8'h01; ci = 1'b0; dec = 1'b1;
        exp_v = model(8'h99, 8'h01, 1'b0, 1'b1, S_ADD, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_after_done: got busy=%b, required 1", busy);
        end
        wait_cnt = 0;
        while (!done && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        n_checks++;
        if (!done || {result, flag_c, flag_v, flag_n, flag_z} !== exp_v) begin
            n_fail++;
            $display("FAIL after_done_result: got done=%b value=%h, required done=1 value=%h", done,
                     {result, flag_c, flag_v, flag_n, flag_z}, exp_v);
        end
        $display("op a=99 b=01 dec after done -> result=%h C=%b Z=%b", result, flag_c, flag_z);
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, dones;
        run_op(8'h3C, 8'h4A, 1'b0, 1'b1, S_ADD, 1'b0, 1'b0, lat, bc);
        @(negedge clk);
        a = 8'h11; b = 8'h22; ci = 1'b0; m = 1'b1; s = S_ADD; sub = 1'b0; dec = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, result, flag_c, flag_v, flag_n, flag_z} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h flags=%b%b%b%b, required all 0",
                     busy, done, result, flag_c, flag_v, flag_n, flag_z);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL no_done_after_reset: got %0d active cycles, required 0", dones);
        end
        $display("reset mid-run -> result=%h busy=%b", result, busy);
        run_op(8'h58, 8'h46, 1'b1, 1'b1, S_ADD, 1'b0, 1'b1, lat, bc);
        n_checks++;
        if ({result, flag_c, flag_v, flag_n, flag_z} !== model(8'h58, 8'h46, 1'b1, 1'b1, S_ADD, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL post_reset_op: got %h, required %h", {result, flag_c, flag_v, flag_n, flag_z},
                     model(8'h58, 8'h46, 1'b1, 1'b1, S_ADD, 1'b0, 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_binary_add();
        test_decimal_add();
        test_decimal_sub();
        test_binary_sub_zero();
        test_logic();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Nibble-serial sequencer that runs an N-nibble ALU operation through a single alu4 4-bit slice, low nibble first.
- Chains carry between passes and applies per-nibble decimal (BCD) adjust.
- Registers the assembled result and the 6502 flags N, Z, C, V.
- Sits between the operand/decode stage and the flags/accumulator write-back.

Parameters:
- NIBBLES, 2, number of 4-bit passes; datapath width W = 4*NIBBLES; minimum 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  W  operand A
- b  in  W  operand B
- ci  in  1  carry in; for subtract, 1 = no borrow
- m  in  1  passed to slice M; 1 = arithmetic with carry chain
- s  in  4  passed to slice S (operation select)
- sub  in  1  operation is subtract; used for V and decimal adjust
- dec  in  1  decimal mode; honoured only when m=1
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE
- result  out  W  registered result
- flag_c, flag_v, flag_n, flag_z  out  1 each  registered flags

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, all flags=0, nibble counter=0, carry register=0.
- Reset mid-operation aborts immediately. No done pulse is produced, and the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on an edge with start=1, latch a, b, ci, m, s, sub, dec; set cnt=0, carry=ci; go to RUN.
  - RUN: each edge processes nibble cnt. The slice gets A=a_l[4cnt+3:4cnt], B=b_l[same], CI=carry, M=m_l, S=s_l.
    - Write the adjusted nibble into the result shift/assembly register.
    - Update carry with the adjusted carry; cnt++.
    - On the edge processing cnt=NIBBLES-1, update result and flags together and go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored in RUN and DONE. No queueing.
- Latency: start sampled at edge T0. done is high during the cycle following edge T0+NIBBLES (NIBBLES=2: after the 2nd edge past T0).
- result and flags update only on the final RUN edge. They hold their values until the next operation's final edge. busy and done are registered.
- Decimal adjust (m=1, dec=1), per nibble, with f = slice F and co = slice CO:
  - Add (sub=0): if co=1 or f>9, then f'=(f+6) mod 16 and carry'=1. Otherwise f'=f and carry'=co.
  - Subtract (sub=1): if co=0 (borrow), then f'=(f-6) mod 16. carry'=co.
  - Decimal results for non-BCD inputs are unspecified but deterministic. No X propagation.
- Binary (dec=0 or m=0): f'=f, carry'=co.
- Flags on the final edge:
  - N = result[W-1].
  - Z = (result==0).
  - C = final carry' if m=1; C = latched ci if m=0.
  - V (m=1) = (a[W-1] == (b[W-1]^sub)) & (binary f of top nibble, bit3, != a[W-1]). V is computed from the binary (pre-adjust) top-nibble bit.
  - V (m=0) = 0.
- Slice G and P outputs are unused.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum (IDLE, RUN, DONE), 2-bit encoding;
  - localparams S_ADD=4'b1001 and S_SUB=4'b0110 (A minus B, ci=1 meaning no borrow), for use by benches and decode;
  - BCD constants DEC_LIMIT=9 and DEC_ADJ=6.
- One sub-module: a single instance of the existing alu4 slice.
- Decimal adjust and the FSM are inline.

Test Plan:
- Binary add: NIBBLES=2, a=0x3C, b=0x4A, ci=0, m=1, s=S_ADD, sub=0, dec=0 -> result=0x86, C=0, V=1, N=1, Z=0. done pulses once, 2 edges after start; busy high for exactly 2 cycles.
- Decimal add: a=0x58, b=0x46, ci=1, dec=1, s=S_ADD -> result=0x05, C=1, N=0, Z=0.
- Decimal subtract: a=0x32, b=0x15, ci=1, sub=1, dec=1, s=S_SUB -> result=0x17, C=1 (low nibble borrow: 0xD adjusted to 0x7, propagates 0 into the high pass).
- Binary subtract to zero: a=0x50, b=0x50, ci=1, sub=1, s=S_SUB -> result=0x00, Z=1, C=1, V=0, N=0.
- Back-to-back and overlap:
  - Pulse start again during RUN and during DONE -> ignored. Exactly one done; result matches the first operands.
  - A new start in the cycle after DONE is accepted.
- Reset mid-run: assert rst on the cycle after start -> busy=0, done=0, result=0, all flags=0 asynchronously. No done pulse follows release. The next operation completes normally.
